// File: rtl/cdr_rx_pkg.sv
// Shared types and defaults for the cdr_rx receive front-end.
// Holds the framing FSM state encoding and the 2-of-3 vote helper.
package cdr_rx_pkg;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_SFD  = 2'd1,
        S_PHR  = 2'd2,
        S_DATA = 2'd3
    } cdr_state_t;

    localparam logic [7:0] SFD_DEFAULT      = 8'hA7;
    localparam int         OSR_DEFAULT      = 8;
    localparam int         PREAMBLE_DEFAULT = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cdr_rx_sampler.sv
// Bit-timing recovery: rx_in synchronizer, edge detect, edge-aligned phase counter
// and a 2-of-3 vote over the three centre samples of each bit.
module cdr_sampler
    import cdr_rx_pkg::*;
#(
    parameter int OSR = OSR_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_en,
    input  logic rx_in,
    output logic bit_valid,
    output logic data_out
);

    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] PH_LO   = PW'(OSR / 2 - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(OSR / 2);
    localparam logic [PW-1:0] PH_HI   = PW'(OSR / 2 + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

    // [0] metastability stage, [1] synced sample, [2] delayed copy for edge detect
    logic [2:0]    sync_q;
    logic [PW-1:0] phase;
    logic          samp_lo;
    logic          samp_mid;
    logic          edge_det;
    logic          in_window;

    assign edge_det  = sync_q[1] ^ sync_q[2];
    assign in_window = (phase >= PH_LO) && (phase <= PH_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            phase     <= '0;
            samp_lo   <= 1'b0;
            samp_mid  <= 1'b0;
            bit_valid <= 1'b0;
            data_out  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], rx_in};
            bit_valid <= 1'b0;
            if (!rx_en) begin
                phase    <= '0;
                samp_lo  <= 1'b0;
                samp_mid <= 1'b0;
            end else begin
                // edges inside the sample window are treated as glitches
                if (edge_det && !in_window) begin
                    phase <= '0;
                end else if (phase == PH_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
                if (phase == PH_LO) begin
                    samp_lo <= sync_q[1];
                end
                if (phase == PH_MID) begin
                    samp_mid <= sync_q[1];
                end
                if (phase == PH_HI) begin
                    bit_valid <= 1'b1;
                    data_out  <= majority3(samp_lo, samp_mid, sync_q[1]);
                end
            end
        end
    end

endmodule

// File: rtl/cdr_rx.sv
// Receive front-end: recovered bits are framed into preamble / SFD / PHR / payload,
// and every completed PHR or payload byte is strobed out to the RX FIFO via en_cdr.
//
// state  | meaning
// HUNT   | counting consecutive zero bits of the preamble
// SFD    | preamble seen, sliding 8-bit window compared against SFD
// PHR    | assembling the length byte
// DATA   | assembling payload bytes until len bytes are done
module cdr_rx
    import cdr_rx_pkg::*;
#(
    parameter int         OSR           = OSR_DEFAULT,
    parameter int         PREAMBLE_BITS = PREAMBLE_DEFAULT,
    parameter logic [7:0] SFD           = SFD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic       data_out,
    output logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       en_cdr,
    output logic       sync_lock,
    output logic       frame_done
);

    localparam int ZW = $clog2(PREAMBLE_BITS + 1);

    cdr_state_t    state;
    logic [7:0]    shreg;
    logic [7:0]    window;
    logic [2:0]    bit_cnt;
    logic [ZW-1:0] zero_cnt;
    logic [3:0]    miss_cnt;
    logic [6:0]    len;
    logic [6:0]    byte_cnt;
    logic [7:0]    new_byte;
    logic [7:0]    new_win;
    logic          bit_go;

    cdr_sampler #(
        .OSR (OSR)
    ) u_sampler (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_en     (rx_en),
        .rx_in     (rx_in),
        .bit_valid (bit_valid),
        .data_out  (data_out)
    );

    assign new_byte = {data_out, shreg[7:1]};
    assign new_win  = {data_out, window[7:1]};
    assign bit_go   = bit_valid & rx_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HUNT;
            shreg      <= '0;
            window     <= '0;
            bit_cnt    <= '0;
            zero_cnt   <= '0;
            miss_cnt   <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            byte_out   <= '0;
            en_cdr     <= 1'b0;
            sync_lock  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            en_cdr     <= 1'b0;
            frame_done <= 1'b0;
            if (!rx_en) begin
                state     <= S_HUNT;
                shreg     <= '0;
                window    <= '0;
                bit_cnt   <= '0;
                zero_cnt  <= '0;
                miss_cnt  <= '0;
                len       <= '0;
                byte_cnt  <= '0;
                sync_lock <= 1'b0;
            end else if (bit_go) begin
                case (state)
                    S_HUNT: begin
                        if (data_out) begin
                            zero_cnt <= '0;
                        end else if (zero_cnt == ZW'(PREAMBLE_BITS - 1)) begin
                            zero_cnt <= ZW'(PREAMBLE_BITS);
                            window   <= '0;
                            miss_cnt <= '0;
                            state    <= S_SFD;
                        end else begin
                            zero_cnt <= zero_cnt + 1'b1;
                        end
                    end
                    S_SFD: begin
                        window <= new_win;
                        if (new_win == SFD) begin
                            shreg     <= '0;
                            bit_cnt   <= '0;
                            sync_lock <= 1'b1;
                            state     <= S_PHR;
                        end else if (new_win == 8'h00) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == 4'd7) begin
                            miss_cnt <= '0;
                            zero_cnt <= '0;
                            state    <= S_HUNT;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                    S_PHR, S_DATA: begin
                        shreg   <= new_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            byte_out <= new_byte;
                            en_cdr   <= 1'b1;
                            if (state == S_PHR) begin
                                len      <= new_byte[6:0];
                                byte_cnt <= '0;
                                if (new_byte[6:0] == 7'd0) begin
                                    frame_done <= 1'b1;
                                    sync_lock  <= 1'b0;
                                    zero_cnt   <= '0;
                                    state      <= S_HUNT;
                                end else begin
                                    state <= S_DATA;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                                if (byte_cnt + 7'd1 == len) begin
                                    frame_done <= 1'b1;
                                    sync_lock  <= 1'b0;
                                    zero_cnt   <= '0;
                                    state      <= S_HUNT;
                                end
                            end
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdr_rx.sv
// Directed bench for cdr_rx: a table of whole frames plus hand-written abort and
// wrong-SFD sequences, checked against hand-computed byte streams.
module tb_cdr_rx;
    import cdr_rx_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       rx_en;
    logic       rx_in;
    logic       data_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       en_cdr;
    logic       sync_lock;
    logic       frame_done;

    cdr_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_en      (rx_en),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .en_cdr     (en_cdr),
        .sync_lock  (sync_lock),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      nzero;
        logic [7:0]      sfd;
        logic [7:0]      phr;
        logic [2:0][7:0] pay;
        logic [1:0]      npay;
        logic            drift;
        logic [2:0]      exp_en;
        logic [3:0][7:0] exp_b;
        logic            exp_fd;
        logic            exp_lock;
    } vec_t;

    vec_t vecs [4];

    int total = 0;
    int bad   = 0;

    // monitor: byte log of every en_cdr strobe and pulse counters
    logic [7:0] byte_log [256];
    int en_total    = 0;
    int fd_total    = 0;
    int fd_with_en  = 0;
    int lock_cycles = 0;

    always @(negedge clk) begin
        if (en_cdr) begin
            if (en_total < 256) byte_log[en_total] <= byte_out;
            en_total <= en_total + 1;
            if (frame_done) fd_with_en <= fd_with_en + 1;
        end
        if (frame_done) fd_total <= fd_total + 1;
        if (sync_lock) lock_cycles <= lock_cycles + 1;
    end

    bit drift_on = 1'b0;
    bit tog      = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // drift mode alternates 7/9-cycle bits; 9-cycle bits carry a 1-cycle glitch at the centre
    task automatic send_bit(input logic b);
        if (!drift_on) begin
            drive(b, 8);
        end else begin
            if (tog) begin
                drive(b, 5);
                drive(!b, 1);
                drive(b, 3);
            end else begin
                drive(b, 7);
            end
            tog = !tog;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_frame(input vec_t v);
        drift_on = 1'b0;
        repeat (4) send_bit(1'b1);
        drift_on = v.drift;
        tog      = 1'b0;
        repeat (int'(v.nzero)) send_bit(1'b0);
        send_byte(v.sfd);
        send_byte(v.phr);
        for (int i = 0; i < int'(v.npay); i++) send_byte(v.pay[i]);
        drift_on = 1'b0;
        repeat (4) send_bit(1'b1);
    endtask

    // idle, 32 zeros, SFD, PHR 03, payload 11, then half of 22
    task automatic send_partial();
        drift_on = 1'b0;
        repeat (4) send_bit(1'b1);
        repeat (32) send_bit(1'b0);
        send_byte(8'hA7);
        send_byte(8'h03);
        send_byte(8'h11);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
    endtask

    task automatic check_nominal(input string tag);
        int e0;
        int f0;
        int w0;
        int l0;
        e0 = en_total;
        f0 = fd_total;
        w0 = fd_with_en;
        l0 = lock_cycles;
        send_frame(vecs[0]);
        repeat (10) @(negedge clk);
        check({tag, "_en_count"}, en_total - e0, 4);
        if (en_total - e0 == 4) begin
            check({tag, "_b0"}, 32'(byte_log[e0]),     32'h03);
            check({tag, "_b1"}, 32'(byte_log[e0 + 1]), 32'h11);
            check({tag, "_b2"}, 32'(byte_log[e0 + 2]), 32'h22);
            check({tag, "_b3"}, 32'(byte_log[e0 + 3]), 32'h33);
        end
        check({tag, "_fd_with_en"}, fd_with_en - w0, 1);
        check({tag, "_fd_count"}, fd_total - f0, 1);
        check({tag, "_lock_seen"}, 32'(lock_cycles > l0), 1);
        check({tag, "_lock_end"}, 32'(sync_lock), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int f0;
        int w0;
        int l0;

        vecs[0] = '{nzero: 8'd32, sfd: 8'hA7, phr: 8'h03, pay: {8'h33, 8'h22, 8'h11},
                    npay: 2'd3, drift: 1'b0, exp_en: 3'd4,
                    exp_b: {8'h33, 8'h22, 8'h11, 8'h03}, exp_fd: 1'b1, exp_lock: 1'b1};
        vecs[1] = '{nzero: 8'd24, sfd: 8'hA7, phr: 8'h03, pay: {8'h33, 8'h22, 8'h11},
                    npay: 2'd3, drift: 1'b0, exp_en: 3'd0,
                    exp_b: 32'h0, exp_fd: 1'b0, exp_lock: 1'b0};
        vecs[2] = '{nzero: 8'd32, sfd: 8'hA7, phr: 8'h03, pay: {8'h33, 8'h22, 8'h11},
                    npay: 2'd3, drift: 1'b1, exp_en: 3'd4,
                    exp_b: {8'h33, 8'h22, 8'h11, 8'h03}, exp_fd: 1'b1, exp_lock: 1'b1};
        vecs[3] = '{nzero: 8'd32, sfd: 8'hA7, phr: 8'h00, pay: 24'h0,
                    npay: 2'd0, drift: 1'b0, exp_en: 3'd1,
                    exp_b: 32'h0, exp_fd: 1'b1, exp_lock: 1'b1};

        reset_n = 1'b0;
        rx_en   = 1'b1;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({data_out, bit_valid, byte_out, en_cdr, sync_lock, frame_done}), 0);
        check("reset_state", 32'(dut.state), 32'(S_HUNT));
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            e0 = en_total;
            f0 = fd_total;
            w0 = fd_with_en;
            l0 = lock_cycles;
            send_frame(vecs[v]);
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_en_count", v), en_total - e0, int'(vecs[v].exp_en));
            if (en_total - e0 == int'(vecs[v].exp_en)) begin
                for (int k = 0; k < int'(vecs[v].exp_en); k++)
                    check($sformatf("vec%0d_byte%0d", v, k), 32'(byte_log[e0 + k]),
                          32'(vecs[v].exp_b[k]));
            end
            check($sformatf("vec%0d_fd_count", v), fd_total - f0, int'(vecs[v].exp_fd));
            check($sformatf("vec%0d_fd_with_en", v), fd_with_en - w0, int'(vecs[v].exp_fd));
            check($sformatf("vec%0d_lock_seen", v), 32'(lock_cycles > l0), 32'(vecs[v].exp_lock));
            check($sformatf("vec%0d_lock_end", v), 32'(sync_lock), 0);
            check($sformatf("vec%0d_state_end", v), 32'(dut.state), 32'(S_HUNT));
        end

        // wrong SFD: 40 zeros, A6, 8 ones -> back to HUNT, then a good frame
        e0 = en_total;
        l0 = lock_cycles;
        drift_on = 1'b0;
        repeat (4) send_bit(1'b1);
        repeat (40) send_bit(1'b0);
        send_byte(8'hA6);
        send_byte(8'hFF);
        repeat (12) @(negedge clk);
        check("badsfd_hunt", 32'(dut.state), 32'(S_HUNT));
        check("badsfd_no_en", en_total - e0, 0);
        check("badsfd_no_lock", 32'(lock_cycles > l0), 0);
        check_nominal("after_badsfd");

        // rx_en abort mid-payload
        f0 = fd_total;
        e0 = en_total;
        send_partial();
        rx_en = 1'b0;
        @(negedge clk);
        check("rxen_state", 32'(dut.state), 32'(S_HUNT));
        check("rxen_lock", 32'(sync_lock), 0);
        check("rxen_byte_hold", 32'(byte_out), 32'h11);
        repeat (20) @(negedge clk);
        check("rxen_no_fd", fd_total - f0, 0);
        check("rxen_en_count", en_total - e0, 2);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        check_nominal("after_rxen");

        // reset abort mid-payload: outputs clear without waiting for a clock edge
        f0 = fd_total;
        send_partial();
        reset_n = 1'b0;
        #1;
        check("rst_abort_outputs", 32'({data_out, bit_valid, byte_out, en_cdr, sync_lock, frame_done}), 0);
        @(negedge clk);
        check("rst_abort_state", 32'(dut.state), 32'(S_HUNT));
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_abort_no_fd", fd_total - f0, 0);
        check_nominal("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdr_rx.md
Name: cdr_rx

Overview:
- Receive front-end that sits directly upstream of the RX FIFO.
- Takes the oversampled serial line `rx_in` and recovers bit timing with a phase counter that re-aligns on every line edge.
- Detects the PHY preamble and SFD, then frames the PHR byte and the payload bytes.
- For each completed byte it presents the byte on `byte_out` and issues a one-cycle `en_cdr` strobe for the FIFO write path, with `data_out` carrying the last decided bit.

Parameters:
- OSR, 8: clock cycles per bit. Must be ≥ 6 and even.
- PREAMBLE_BITS, 32: consecutive zero bits required before the SFD search starts.
- SFD, 8'hA7: start-of-frame delimiter, received LSB first.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_en  in  1  receiver enable; low forces HUNT and clears all counters.
- rx_in  in  1  asynchronous serial line, oversampled at clk.
- data_out  out  1  last decided bit, held until the next decision.
- bit_valid  out  1  one-cycle pulse per decided bit.
- byte_out  out  8  last completed byte, held until the next byte.
- en_cdr  out  1  one-cycle pulse for each byte completed in PHR or DATA.
- sync_lock  out  1  high while in PHR or DATA.
- frame_done  out  1  one-cycle pulse when a frame ends normally.

Behaviour:
- Reset: clk and reset_n as stated above. Every output is 0 and the FSM is in HUNT. Phase, bit, byte and zero counters are 0. Reset takes effect immediately, mid-frame included. No en_cdr or frame_done pulse is produced by reset.
- Input synchronizer: 2-FF on rx_in, so 2 cycles of latency. Edge = synced XOR its delayed copy.
- Phase counter: runs 0..OSR-1 and wraps. An edge loads the counter with 0, except edges seen while phase is in the sample window OSR/2-1..OSR/2+1, which are ignored (glitch guard).
- Bit decision: majority of the synced samples at phases OSR/2-1, OSR/2 and OSR/2+1. The decision is made at phase OSR/2+1. In that same cycle bit_valid pulses and data_out updates.
- Byte assembly: bits arrive LSB first. The shift register shifts right with the new bit entering bit 7. A 3-bit bit counter marks each byte complete on its 8th bit.
- HUNT:
  - Zero counter increments on each 0 bit and clears on a 1 bit; it saturates at PREAMBLE_BITS.
  - At saturation → SFD state.
- SFD:
  - An 8-bit window is compared with SFD on every bit.
  - Window == SFD → PHR, with bit counter = 0.
  - Window == 0 keeps searching, so longer preambles are accepted.
  - Otherwise a miss counter increments; it clears whenever the window is 0. Miss counter reaching 8 → HUNT.
- PHR:
  - The 8th bit completes the byte: byte_out ← byte and en_cdr pulses in the cycle after the bit decision.
  - len = byte[6:0].
  - len == 0 → frame_done pulses together with en_cdr, then HUNT. Otherwise → DATA.
- DATA:
  - Each completed byte updates byte_out and pulses en_cdr.
  - A byte counter counts completed bytes. When it reaches len, frame_done pulses together with that en_cdr, then HUNT.
- en_cdr timing: bytes are at least 8*OSR cycles apart, so en_cdr always returns low between pulses, as the FIFO's rising-edge detection requires.
- rx_en deasserted:
  - Next cycle: FSM is in HUNT, all counters are 0, sync_lock = 0.
  - byte_out and data_out hold their values.
  - No frame_done pulse is produced.
- Bit edge cases: a bit decided in the same cycle as rx_en falls is discarded. Edges arriving exactly at the decision phase are ignored per the glitch guard.

Decomposition:
- Package cdr_rx_pkg holds:
  - the state enum {HUNT, SFD, PHR, DATA};
  - SFD_DEFAULT = 8'hA7;
  - OSR_DEFAULT = 8;
  - PREAMBLE_DEFAULT = 32.
- One sub-module, cdr_sampler, contains the synchronizer, edge detect, phase counter and majority vote. Its outputs are bit_valid and data_out.
- The top level, cdr_rx, contains the FSM, shift register and counters.

Test Plan:
- Nominal frame, OSR=8: 32 zero bits, A7, PHR 03, payload 11 22 33. Required response:
  - four en_cdr pulses, with byte_out = 03, 11, 22, 33;
  - frame_done coincides with the fourth pulse;
  - sync_lock is high from the SFD match to the end of the frame, then low.
- Short preamble (24 zeros) followed by A7 and a full frame: no sync_lock and no en_cdr.
- Wrong SFD (40 zeros, then A6, then 8 ones): return to HUNT within 8 bits, no en_cdr. A correct frame sent immediately afterwards decodes normally.
- Timing drift: the nominal frame with bit periods alternating 7 and 9 cycles, plus 1-cycle glitches inside sample windows. Required response: identical decoded bytes 03, 11, 22, 33.
- Zero-length frame (32 zeros, A7, PHR 00): exactly one en_cdr with byte_out = 00, frame_done in the same cycle, HUNT after.
- Abort mid-payload:
  - reset_n low while in DATA: all outputs 0 immediately.
  - rx_en low instead: HUNT the next cycle, byte_out held, no frame_done.
  - A fresh frame afterwards decodes correctly.
